// File: rtl/adc_chan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : adc_chan_sequencer
//  Purpose  : Drives the ADC channel select, drops the settling conversions
//             after every channel switch, averages 2^AVG_LOG2 conversions per
//             channel and publishes the per-channel averages together with an
//             up/down/hold deadband direction code. Flags a stale ADC link
//             when no conversion arrives for TIMEOUT cycles.
//  Options  : ADC_SEQ_HYST_EN - per-channel hysteresis on the direction code
//  Revision : 1.0 - initial release
// ============================================================================
module adc_chan_sequencer #(
    parameter int          NUM_CH   = 2,
    parameter int          DISCARD  = 2,
    parameter int          AVG_LOG2 = 2,
    parameter logic [11:0] HI_TH    = 12'h750,
    parameter logic [11:0] LO_TH    = 12'h500,
    parameter logic [11:0] HYST     = 12'h040,
    parameter int          TIMEOUT  = 50000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        adc_convst,
    input  logic [11:0] adc_result,
    output logic [2:0]  chan,
    output logic [11:0] avg_value,
    output logic [2:0]  avg_chan,
    output logic        avg_valid,
    output logic [11:0] ch0_value,
    output logic [11:0] ch1_value,
    output logic [1:0]  ch0_dir,
    output logic [1:0]  ch1_dir,
    output logic        adc_stale
);

    localparam int ACC_W   = 12 + AVG_LOG2;
    localparam int AVG_N   = 1 << AVG_LOG2;
    localparam int STALE_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        S_SWITCH  = 2'd0,
        S_DISCARD = 2'd1,
        S_ACCUM   = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Direction classification. A history of HOLD means "plain thresholds";
    // the keep-bands only matter when a previous UP/DOWN code is fed back.
    // ------------------------------------------------------------------------
    function automatic logic [1:0] classify(input logic [11:0] v, input logic [1:0] prev);
        logic [1:0] d;
        if (v > HI_TH)      d = DIR_UP;
        else if (v < LO_TH) d = DIR_DOWN;
        else                d = DIR_HOLD;
        if ((prev == DIR_UP) && (v > (HI_TH - HYST)))
            d = DIR_UP;
        else if ((prev == DIR_DOWN) && (v < (LO_TH + HYST)))
            d = DIR_DOWN;
        return d;
    endfunction

    // Synchronizer, edge detector and stale-link state
    logic               sync1_q, sync2_q, prev_q, strobe_q;
    logic               strobe_d;
    logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;
    logic               adc_stale_q, adc_stale_d;

    // Sequencer state
    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [2:0]         ch_idx_q, ch_idx_d;
    logic [2:0]         chan_q, chan_d;
    logic [11:0]        avg_value_q, avg_value_d;
    logic [2:0]         avg_chan_q, avg_chan_d;
    logic               avg_valid_q, avg_valid_d;
    logic [11:0]        ch0_value_q, ch0_value_d;
    logic [11:0]        ch1_value_q, ch1_value_d;
    logic [1:0]         ch0_dir_q, ch0_dir_d;
    logic [1:0]         ch1_dir_q, ch1_dir_d;

    logic [ACC_W-1:0]   sum_w;
    logic [11:0]        avg_w;
    logic [1:0]         ch0_prev_w, ch1_prev_w;

    assign sum_w = acc_q + ACC_W'(adc_result);
    assign avg_w = sum_w[ACC_W-1:AVG_LOG2];

`ifdef ADC_SEQ_HYST_EN
    assign ch0_prev_w = ch0_dir_q;
    assign ch1_prev_w = ch1_dir_q;
`else
    assign ch0_prev_w = DIR_HOLD;
    assign ch1_prev_w = DIR_HOLD;
`endif

    // Rising edge of the synchronized convst becomes a one-cycle strobe
    always_comb begin
        strobe_d = sync2_q & ~prev_q;
    end

    // Stale counter restarts on every strobe and saturates at TIMEOUT
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (strobe_q)
            stale_cnt_d = '0;
        else if (stale_cnt_q != STALE_W'(TIMEOUT))
            stale_cnt_d = stale_cnt_q + 1'b1;
        adc_stale_d = (stale_cnt_d == STALE_W'(TIMEOUT));
    end

    // Synchronizer, edge register and stale tracking flops
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            strobe_q    <= 1'b0;
            stale_cnt_q <= '0;
            adc_stale_q <= 1'b0;
        end else begin
            sync1_q     <= adc_convst;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            strobe_q    <= strobe_d;
            stale_cnt_q <= stale_cnt_d;
            adc_stale_q <= adc_stale_d;
        end
    end

    // Sequencer next-state: switch, drop settling samples, accumulate, publish.
    // Results are registered on the completing strobe so they are visible
    // during the PUBLISH cycle together with the avg_valid pulse.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ch_idx_d    = ch_idx_q;
        chan_d      = chan_q;
        avg_value_d = avg_value_q;
        avg_chan_d  = avg_chan_q;
        avg_valid_d = 1'b0;
        ch0_value_d = ch0_value_q;
        ch1_value_d = ch1_value_q;
        ch0_dir_d   = ch0_dir_q;
        ch1_dir_d   = ch1_dir_q;
        case (state_q)
            S_SWITCH: begin
                chan_d  = ch_idx_q;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = (DISCARD == 0) ? S_ACCUM : S_DISCARD;
            end
            S_DISCARD: begin
                if (strobe_q) begin
                    if (cnt_q == 5'(DISCARD - 1)) begin
                        cnt_d   = '0;
                        state_d = S_ACCUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                if (strobe_q) begin
                    acc_d = sum_w;
                    if (cnt_q == 5'(AVG_N - 1)) begin
                        state_d     = S_PUBLISH;
                        avg_value_d = avg_w;
                        avg_chan_d  = ch_idx_q;
                        avg_valid_d = 1'b1;
                        if (ch_idx_q == 3'd0) begin
                            ch0_value_d = avg_w;
                            ch0_dir_d   = classify(avg_w, ch0_prev_w);
                        end
                        if (ch_idx_q == 3'd1) begin
                            ch1_value_d = avg_w;
                            ch1_dir_d   = classify(avg_w, ch1_prev_w);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PUBLISH: begin
                ch_idx_d = (ch_idx_q == 3'(NUM_CH - 1)) ? 3'd0 : ch_idx_q + 3'd1;
                state_d  = S_SWITCH;
            end
            default: begin
                state_d = S_SWITCH;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_SWITCH;
            cnt_q       <= '0;
            acc_q       <= '0;
            ch_idx_q    <= '0;
            chan_q      <= '0;
            avg_value_q <= '0;
            avg_chan_q  <= '0;
            avg_valid_q <= 1'b0;
            ch0_value_q <= '0;
            ch1_value_q <= '0;
            ch0_dir_q   <= DIR_HOLD;
            ch1_dir_q   <= DIR_HOLD;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ch_idx_q    <= ch_idx_d;
            chan_q      <= chan_d;
            avg_value_q <= avg_value_d;
            avg_chan_q  <= avg_chan_d;
            avg_valid_q <= avg_valid_d;
            ch0_value_q <= ch0_value_d;
            ch1_value_q <= ch1_value_d;
            ch0_dir_q   <= ch0_dir_d;
            ch1_dir_q   <= ch1_dir_d;
        end
    end

    assign chan      = chan_q;
    assign avg_value = avg_value_q;
    assign avg_chan  = avg_chan_q;
    assign avg_valid = avg_valid_q;
    assign ch0_value = ch0_value_q;
    assign ch1_value = ch1_value_q;
    // A stale link must not keep the servos moving: directions read HOLD
    assign ch0_dir   = adc_stale_q ? DIR_HOLD : ch0_dir_q;
    assign ch1_dir   = adc_stale_q ? DIR_HOLD : ch1_dir_q;
    assign adc_stale = adc_stale_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_chan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_chan_sequencer
//  Purpose  : Self-checking bench for adc_chan_sequencer (default parameters).
//             Honours ADC_SEQ_HYST_EN when the design is built with it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_chan_sequencer;

    localparam int          NUM_CH   = 2;
    localparam int          DISCARD  = 2;
    localparam int          AVG_LOG2 = 2;
    localparam int          NAVG     = 1 << AVG_LOG2;
    localparam int          RLEN     = DISCARD + NAVG;
    localparam logic [11:0] HI_TH    = 12'h750;
    localparam logic [11:0] LO_TH    = 12'h500;
    localparam logic [11:0] HYST     = 12'h040;
    localparam int          TIMEOUT  = 50000;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        adc_convst;
    logic [11:0] adc_result;
    logic [2:0]  chan;
    logic [11:0] avg_value;
    logic [2:0]  avg_chan;
    logic        avg_valid;
    logic [11:0] ch0_value, ch1_value;
    logic [1:0]  ch0_dir, ch1_dir;
    logic        adc_stale;

    int checks = 0;
    int errors = 0;

    adc_chan_sequencer #(
        .NUM_CH  (NUM_CH),
        .DISCARD (DISCARD),
        .AVG_LOG2(AVG_LOG2),
        .HI_TH   (HI_TH),
        .LO_TH   (LO_TH),
        .HYST    (HYST),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .adc_convst(adc_convst),
        .adc_result(adc_result),
        .chan      (chan),
        .avg_value (avg_value),
        .avg_chan  (avg_chan),
        .avg_valid (avg_valid),
        .ch0_value (ch0_value),
        .ch1_value (ch1_value),
        .ch0_dir   (ch0_dir),
        .ch1_dir   (ch1_dir),
        .adc_stale (adc_stale)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  ch;
        logic [11:0] avg;
        logic [1:0]  dir;
    } pub_t;

    pub_t        exp_q[$];
    pub_t        mon_e;
    int          conv_idx;
    int          acc_sum;
    logic [1:0]  m_dir[2];

    function automatic logic [1:0] ref_dir(input logic [11:0] v, input logic [1:0] prev);
        logic [1:0] d;
        d = (v > HI_TH) ? 2'b01 : (v < LO_TH) ? 2'b10 : 2'b00;
`ifdef ADC_SEQ_HYST_EN
        if (prev == 2'b01 && int'(v) > int'(HI_TH) - int'(HYST)) d = 2'b01;
        if (prev == 2'b10 && int'(v) < int'(LO_TH) + int'(HYST)) d = 2'b10;
`else
        if (prev == 2'b11) d = 2'b11;
`endif
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One ADC conversion, value chosen by the currently selected channel.
    task automatic convert(input logic [11:0] v0, input logic [11:0] v1);
        logic [11:0] v;
        int p, r;
        pub_t e;
        @(negedge CLOCK_50);
        p = conv_idx % RLEN;
        r = conv_idx / RLEN;
        check("chan", {29'd0, chan}, r % NUM_CH);
        v = (chan == 3'd0) ? v0 : v1;
        adc_result = v;
        adc_convst = 1'b1;
        if (p == 0) acc_sum = 0;
        if (p >= DISCARD) acc_sum += int'(v);
        if (p == RLEN - 1) begin
            e.ch  = 3'(r % NUM_CH);
            e.avg = 12'(acc_sum / NAVG);
            e.dir = 2'b00;
            if (e.ch < 3'd2) begin
                e.dir = ref_dir(e.avg, m_dir[e.ch[0]]);
                m_dir[e.ch[0]] = e.dir;
            end
            exp_q.push_back(e);
        end
        conv_idx++;
        repeat (6) @(negedge CLOCK_50);
        adc_convst = 1'b0;
        repeat (6) @(negedge CLOCK_50);
    endtask

    task automatic align(input int modulo);
        while (conv_idx % modulo != 0) convert(12'h600, 12'h600);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        conv_idx = 0;
        acc_sum  = 0;
        exp_q.delete();
        m_dir[0] = 2'b00;
        m_dir[1] = 2'b00;
        check("rst_chan",      {29'd0, chan},      0);
        check("rst_avg_value", {20'd0, avg_value}, 0);
        check("rst_avg_chan",  {29'd0, avg_chan},  0);
        check("rst_avg_valid", {31'd0, avg_valid}, 0);
        check("rst_ch0_value", {20'd0, ch0_value}, 0);
        check("rst_ch1_value", {20'd0, ch1_value}, 0);
        check("rst_ch0_dir",   {30'd0, ch0_dir},   0);
        check("rst_ch1_dir",   {30'd0, ch1_dir},   0);
        check("rst_adc_stale", {31'd0, adc_stale}, 0);
    endtask

    // Scoreboard: every avg_valid pulse must match the next modelled publish
    always @(negedge CLOCK_50) begin
        if (avg_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_avg_valid: got 1 expected 0");
            end else begin
                mon_e = exp_q.pop_front();
                check("avg_value", {20'd0, avg_value}, {20'd0, mon_e.avg});
                check("avg_chan",  {29'd0, avg_chan},  {29'd0, mon_e.ch});
                if (mon_e.ch == 3'd0) begin
                    check("ch0_value", {20'd0, ch0_value}, {20'd0, mon_e.avg});
                    check("ch0_dir",   {30'd0, ch0_dir},   {30'd0, mon_e.dir});
                end else if (mon_e.ch == 3'd1) begin
                    check("ch1_value", {20'd0, ch1_value}, {20'd0, mon_e.avg});
                    check("ch1_dir",   {30'd0, ch1_dir},   {30'd0, mon_e.dir});
                end
            end
        end
    end

    // Watchdog
    initial begin
        #1_800_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [11:0] v0;
        logic [11:0] v1;
        logic [1:0]  d0;
        logic [1:0]  d1;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [11:0] r0, r1;
        tbl[0] = '{12'h600, 12'h600, 2'b00, 2'b00};
        tbl[1] = '{12'h800, 12'h100, 2'b01, 2'b10};
        tbl[2] = '{12'h600, 12'h600, 2'b00, 2'b00};
        tbl[3] = '{12'h751, 12'h4FF, 2'b01, 2'b10};
        tbl[4] = '{12'hFFF, 12'h000, 2'b01, 2'b10};
        tbl[5] = '{12'h600, 12'h600, 2'b00, 2'b00};
        tbl[6] = '{12'h750, 12'h500, 2'b00, 2'b00};
        tbl[7] = '{12'h501, 12'h74F, 2'b00, 2'b00};

        reset      = 1'b1;
        adc_convst = 1'b0;
        adc_result = 12'h000;
        conv_idx   = 0;
        acc_sum    = 0;
        m_dir[0]   = 2'b00;
        m_dir[1]   = 2'b00;
        repeat (3) @(negedge CLOCK_50);
        do_reset();

        // First publish after DISCARD + 2^AVG_LOG2 strobes, channel 0
        for (int i = 0; i < RLEN; i++) convert(12'h600, 12'h600);
        check("first_avg_chan",  {29'd0, avg_chan},  0);
        check("first_avg_value", {20'd0, avg_value}, 32'h600);
        check("first_ch0_dir",   {30'd0, ch0_dir},   0);

        // Table: constant per-channel levels, four rounds each
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4 * RLEN; i++) convert(tbl[k].v0, tbl[k].v1);
            check("tbl_ch0_value", {20'd0, ch0_value}, {20'd0, tbl[k].v0});
            check("tbl_ch1_value", {20'd0, ch1_value}, {20'd0, tbl[k].v1});
            check("tbl_ch0_dir",   {30'd0, ch0_dir},   {30'd0, tbl[k].d0});
            check("tbl_ch1_dir",   {30'd0, ch1_dir},   {30'd0, tbl[k].d1});
        end

        // Truncation, with full-scale discards that must not leak in
        align(RLEN);
        for (int i = 0; i < DISCARD; i++) convert(12'hFFF, 12'hFFF);
        convert(12'h001, 12'h001);
        convert(12'h001, 12'h001);
        convert(12'h001, 12'h001);
        convert(12'h002, 12'h002);
        check("trunc_avg", {20'd0, avg_value}, 32'h001);
        for (int i = 0; i < RLEN; i++) convert(12'hFFF, 12'hFFF);
        check("fullscale_avg", {20'd0, avg_value}, 32'hFFF);

        // Direction hysteresis on channel 0
        align(RLEN * NUM_CH);
        for (int i = 0; i < RLEN * NUM_CH; i++) convert(12'h760, 12'h600);
        check("hyst_760_dir", {30'd0, ch0_dir}, 32'h1);
        for (int i = 0; i < RLEN * NUM_CH; i++) convert(12'h720, 12'h600);
`ifdef ADC_SEQ_HYST_EN
        check("hyst_720_dir", {30'd0, ch0_dir}, 32'h1);
`else
        check("hyst_720_dir", {30'd0, ch0_dir}, 32'h0);
`endif
        for (int i = 0; i < RLEN * NUM_CH; i++) convert(12'h700, 12'h600);
        check("hyst_700_dir", {30'd0, ch0_dir}, 32'h0);

        // Random levels checked by the scoreboard
        for (int i = 0; i < 60; i++) begin
            r0 = 12'($urandom);
            r1 = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(32'h4C0, 32'h790)) : 12'($urandom);
            convert(r0, r1);
        end

        // Reset in the middle of ACCUM
        align(RLEN);
        for (int i = 0; i < DISCARD + 2; i++) convert(12'h7AA, 12'h7AA);
        do_reset();
        for (int i = 0; i < RLEN; i++) convert(12'h321, 12'h321);
        check("post_rst_avg_chan",  {29'd0, avg_chan},  0);
        check("post_rst_avg_value", {20'd0, avg_value}, 32'h321);

        // Stale link
        align(RLEN * NUM_CH);
        for (int i = 0; i < RLEN * NUM_CH; i++) convert(12'h800, 12'h100);
        check("pre_stale_ch0_dir", {30'd0, ch0_dir}, 32'h1);
        check("pre_stale_ch1_dir", {30'd0, ch1_dir}, 32'h2);
        repeat (TIMEOUT - 20) @(negedge CLOCK_50);
        check("stale_before_timeout", {31'd0, adc_stale}, 0);
        repeat (20) @(negedge CLOCK_50);
        check("stale_at_timeout", {31'd0, adc_stale}, 1);
        check("stale_ch0_dir",    {30'd0, ch0_dir},   0);
        check("stale_ch1_dir",    {30'd0, ch1_dir},   0);
        check("stale_ch0_value",  {20'd0, ch0_value}, 32'h800);
        check("stale_ch1_value",  {20'd0, ch1_value}, 32'h100);
        convert(12'h800, 12'h100);
        check("stale_cleared",       {31'd0, adc_stale}, 0);
        check("stale_clr_ch0_dir",   {30'd0, ch0_dir},   32'h1);
        check("stale_clr_ch1_dir",   {30'd0, ch1_dir},   32'h2);
        for (int i = 0; i < RLEN * NUM_CH; i++) convert(12'h600, 12'h600);

        repeat (10) @(negedge CLOCK_50);
        check("pending_publishes", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
